fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage sitting directly upstream of the branch target buffer and downstream-facing to decode. It owns the program counter and presents it to the BTB and the I-cache each cycle. It captures the fetched word together with its PC and the BTB taken prediction into a 2-entry fetch queue feeding decode. It redirects on BTB flush and discards all wrong-path work.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- pc_1  out  32  current fetch PC; drives BTB instructionPC_1
- bp_next_pc  in  32  BTB branchPC (predicted next PC, or redirect target when bp_flush=1)
- bp_taken  in  1  BTB prediction for pc_1
- bp_flush  in  1  BTB misprediction redirect
- icache_read  out  1  fetch request for address pc_1
- icache_addr  out  30  pc_1[31:2]
- icache_stall  in  1  I-cache not able to complete this cycle
- icache_rdata  in  32  instruction word; valid in any cycle with icache_read=1 and icache_stall=0
- id_valid  out  1  queue head valid
- id_ready  in  1  decode accepts head this cycle
- id_inst  out  32  head instruction
- id_pc  out  32  head PC
- id_pred_taken  out  1  head BTB prediction; carried down the pipe to become the BTB's prev_taken_3

## Operation
- State: pc_r (32b), queue of 2 entries {inst[31:0], pc[31:0], pred}, wr_ptr (1b), rd_ptr (1b), count (2b, range 0..2).
- pc_1 = pc_r; icache_addr = pc_r[31:2].
- deq = id_valid & id_ready; space = (count < 2) | deq.
- icache_read = rst_n & ~bp_flush & space.
- fetch_done = icache_read & ~icache_stall.
- Per clock, in priority order:
  - rst_n=0: pc_r <= RESET_PC; count <= 0; wr_ptr <= 0; rd_ptr <= 0.
  - bp_flush=1: pc_r <= bp_next_pc; count <= 0; wr_ptr <= rd_ptr <= 0. Nothing is enqueued. Queue entries are discarded even if deq=1 in the same cycle. The handshake with decode still completes; decode squashes its own wrong-path work.
  - fetch_done: write {icache_rdata, pc_r, bp_taken} at wr_ptr; wr_ptr <= wr_ptr+1; pc_r <= bp_next_pc.
  - else: pc_r holds.
  - deq (non-flush): rd_ptr <= rd_ptr+1.
  - count <= count + fetch_done - deq (non-flush).
- Pointers wrap modulo 2. Enqueue and dequeue in the same cycle when count=2 is legal; count stays 2.
- id_valid = (count != 0). id_inst, id_pc and id_pred_taken always show the entry at rd_ptr. Their values are don't-care when id_valid=0.
- Queue full (count=2, no deq): icache_read=0 and pc_r holds. The BTB prediction is re-evaluated on the same pc_r the next cycle.
- Queue empty: id_valid=0; decode sees no bypass of icache_rdata.
- pred stored is bp_taken sampled in the fetch_done cycle. bp_next_pc is pc_r+4 or the BTB target accordingly.

## Timing
- Reset values: pc_1=RESET_PC, id_valid=0, count=0, icache_read=0 while rst_n=0. icache_read=1 in the first cycle after reset release.
- Fetch-to-decode latency: 1 cycle. A word fetched in cycle N appears at id_* with id_valid=1 in cycle N+1.
- Redirect latency: bp_flush in cycle N gives pc_1=bp_next_pc in cycle N+1 and id_valid=0 in N+1. The first correct-path word is at decode in N+2 at the earliest.
- icache_stall may last any number of cycles. pc_r, icache_addr and icache_read stay stable through it unless bp_flush arrives.
- A flush during a stall abandons the pending fetch. The new address is presented the next cycle.
- Steady state: 1 instruction per cycle when icache_stall=0 and id_ready=1.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, RESET_PC=0 -> pc_1=0, id_valid=0, icache_read=0. Release -> icache_read=1 and pc_1=0.
- Sequential stream: bp_next_pc=pc+4, bp_taken=0, no stall, id_ready=1 -> id_pc=0,4,8,12 on consecutive cycles with matching id_inst, id_pred_taken=0.
- Predicted taken: at pc=0x8, bp_taken=1, bp_next_pc=0x40 -> entry {pc=0x8, pred=1} enqueued; next pc_1=0x40; id_pc sequence 0x8 then 0x40.
- Backpressure: id_ready=0 for 4 cycles from empty -> count reaches 2 after 2 fetches, icache_read=0, pc_1 holds at 0x8. Raise id_ready -> id_pc=0x0 then 0x4, and fetch at 0x8 resumes the same cycle.
- Flush with full queue and simultaneous deq: count=2, id_ready=1, bp_flush=1, bp_next_pc=0x100 -> next cycle id_valid=0, pc_1=0x100. Following cycle id_pc=0x100.
- Stall then flush: icache_stall=1 for 3 cycles at pc=0x20, then bp_flush with target 0x80 while still stalled -> no entry for 0x20 ever reaches decode; pc_1=0x80 the next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests the I-cache and
// buffers fetched words in a 2-entry queue toward decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_1,
  input  logic [31:0] bp_next_pc,
  input  logic        bp_taken,
  input  logic        bp_flush,
  output logic        icache_read,
  output logic [29:0] icache_addr,
  input  logic        icache_stall,
  input  logic [31:0] icache_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_pred_taken
);

  logic [31:0] pc_r;
  logic [31:0] q_inst [2];
  logic [31:0] q_pc   [2];
  logic [1:0]  q_pred;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  logic deq;
  logic space;
  logic fetch_done;

  assign pc_1        = pc_r;
  assign icache_addr = pc_r[31:2];

  assign deq         = id_valid & id_ready;
  assign space       = (count < 2'd2) | deq;
  assign icache_read = rst_n & ~bp_flush & space;
  assign fetch_done  = icache_read & ~icache_stall;

  assign id_valid      = (count != 2'd0);
  assign id_inst       = q_inst[rd_ptr];
  assign id_pc         = q_pc[rd_ptr];
  assign id_pred_taken = q_pred[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r   <= RESET_PC;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (bp_flush) begin
      // Wrong-path entries die here even if decode takes the head now.
      pc_r   <= bp_next_pc;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (fetch_done) begin
        pc_r   <= bp_next_pc;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (deq)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + {1'b0, fetch_done} - {1'b0, deq};
    end
  end

  // Fetch_done is already gated by reset and flush.
  always_ff @(posedge clk) begin
    if (fetch_done) begin
      q_inst[wr_ptr] <= icache_rdata;
      q_pc[wr_ptr]   <= pc_r;
      q_pred[wr_ptr] <= bp_taken;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, taken
// prediction, backpressure, flush and stall-then-flush.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_1;
  logic [31:0] bp_next_pc;
  logic        bp_taken;
  logic        bp_flush;
  logic        icache_read;
  logic [29:0] icache_addr;
  logic        icache_stall;
  logic [31:0] icache_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_pred_taken;

  logic        use_tgt;
  logic [31:0] tgt;
  int          errors;
  int          checks;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pc_1(pc_1),
    .bp_next_pc(bp_next_pc),
    .bp_taken(bp_taken),
    .bp_flush(bp_flush),
    .icache_read(icache_read),
    .icache_addr(icache_addr),
    .icache_stall(icache_stall),
    .icache_rdata(icache_rdata),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_inst(id_inst),
    .id_pc(id_pc),
    .id_pred_taken(id_pred_taken)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'd7) ^ 32'hA500_0013;
  endfunction

  assign icache_rdata = mem({icache_addr, 2'b00});
  assign bp_next_pc   = use_tgt ? tgt : pc_1 + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bp_taken = 1'b0;
    bp_flush = 1'b0;
    icache_stall = 1'b0;
    id_ready = 1'b1;
    use_tgt = 1'b0;
    tgt = 32'h0;

    // reset held 3 cycles
    step(); step(); step();
    chk("rst_pc", pc_1, 32'h0);
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_read", {31'b0, icache_read}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_read", {31'b0, icache_read}, 32'd1);
    chk("rel_pc", pc_1, 32'h0);

    // sequential stream
    for (int i = 0; i < 4; i++) begin
      step();
      chk("seq_valid", {31'b0, id_valid}, 32'd1);
      chk("seq_pc", id_pc, 32'(4 * i));
      chk("seq_inst", id_inst, mem(32'(4 * i)));
      chk("seq_pred", {31'b0, id_pred_taken}, 32'd0);
    end

    // predicted taken at 0x8
    do_reset();
    step();
    step();
    chk("tk_pc8", pc_1, 32'h8);
    use_tgt = 1'b1;
    tgt = 32'h40;
    bp_taken = 1'b1;
    step();
    use_tgt = 1'b0;
    bp_taken = 1'b0;
    chk("tk_next", pc_1, 32'h40);
    chk("tk_idpc", id_pc, 32'h8);
    chk("tk_pred", {31'b0, id_pred_taken}, 32'd1);
    step();
    chk("tk_idpc2", id_pc, 32'h40);
    chk("tk_pred2", {31'b0, id_pred_taken}, 32'd0);
    chk("tk_inst2", id_inst, mem(32'h40));

    // backpressure from empty
    do_reset();
    id_ready = 1'b0;
    step();
    step();
    chk("bp_read0", {31'b0, icache_read}, 32'd0);
    chk("bp_hold", pc_1, 32'h8);
    chk("bp_head", id_pc, 32'h0);
    step();
    step();
    chk("bp_hold2", pc_1, 32'h8);
    chk("bp_read1", {31'b0, icache_read}, 32'd0);
    id_ready = 1'b1;
    #1;
    chk("bp_resume", {31'b0, icache_read}, 32'd1);
    chk("bp_deq0", id_pc, 32'h0);
    step();
    chk("bp_deq4", id_pc, 32'h4);
    chk("bp_pc", pc_1, 32'hC);
    step();
    chk("bp_deq8", id_pc, 32'h8);

    // flush with full queue and simultaneous deq
    use_tgt = 1'b1;
    tgt = 32'h100;
    bp_flush = 1'b1;
    #1;
    chk("fl_read", {31'b0, icache_read}, 32'd0);
    step();
    bp_flush = 1'b0;
    use_tgt = 1'b0;
    chk("fl_valid", {31'b0, id_valid}, 32'd0);
    chk("fl_pc", pc_1, 32'h100);
    step();
    chk("fl_valid2", {31'b0, id_valid}, 32'd1);
    chk("fl_idpc", id_pc, 32'h100);
    chk("fl_inst", id_inst, mem(32'h100));

    // stall at 0x20, then flush to 0x80 while stalled
    do_reset();
    use_tgt = 1'b1;
    tgt = 32'h20;
    step();
    use_tgt = 1'b0;
    icache_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("st_pc", pc_1, 32'h20);
      chk("st_read", {31'b0, icache_read}, 32'd1);
      step();
    end
    chk("st_empty", {31'b0, id_valid}, 32'd0);
    use_tgt = 1'b1;
    tgt = 32'h80;
    bp_flush = 1'b1;
    step();
    bp_flush = 1'b0;
    use_tgt = 1'b0;
    icache_stall = 1'b0;
    chk("sf_pc", pc_1, 32'h80);
    chk("sf_valid", {31'b0, id_valid}, 32'd0);
    step();
    chk("sf_valid2", {31'b0, id_valid}, 32'd1);
    chk("sf_idpc", id_pc, 32'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
